// File: rtl/axil_traffic_master_if.sv
// AXI4-Lite bus bundle between the traffic master and its slave.
interface axil_traffic_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_traffic_master.sv
// AXI4-Lite traffic generator: writes a counting pattern over DEPTH beats,
// optionally reads it back and counts error responses and data miscompares.
module axil_traffic_master #(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0]  SEED       = DATA_WIDTH'(32'h0000_0007)
) (
    input  logic                  ACLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           resp_err_cnt,
    output logic [15:0]           mismatch_cnt,
    axil_traffic_master_if.master m_axil
);
    localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP, FIN} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            mode_q, mode_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]           err_q, err_d, mis_q, mis_d;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [IDX_W-1:0] i);
        return BASE_ADDR + ADDR_WIDTH'(32'(i) * BYTES);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [IDX_W-1:0] i);
        return SEED + DATA_WIDTH'(i);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign aw_hs   = awvalid_q & m_axil.AWREADY;
    assign w_hs    = wvalid_q & m_axil.WREADY;
    assign b_hs    = bready_q & m_axil.BVALID;
    assign ar_hs   = arvalid_q & m_axil.ARREADY;
    assign r_hs    = rready_q & m_axil.RVALID;
    assign idx_nxt = idx_q + IDX_W'(1);

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        mis_d     = mis_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (mode == 2'd1) begin
                        state_d   = RREQ;
                        arvalid_d = 1'b1;
                        araddr_d  = beat_addr('0);
                    end else begin
                        state_d   = WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awaddr_d  = beat_addr('0);
                        wdata_d   = beat_data('0);
                    end
                end
            end
            WREQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // AW and W may complete in either order or together
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    state_d   = WRESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    idx_d    = idx_nxt;
                    if (m_axil.BRESP != 2'b00) err_d = sat_inc(err_q);
                    if (idx_q == IDX_LAST) begin
                        if (mode_q[1]) begin
                            state_d   = RREQ;
                            arvalid_d = 1'b1;
                            araddr_d  = beat_addr('0);
                        end else begin
                            state_d = FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d   = WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = beat_addr(idx_nxt);
                        wdata_d   = beat_data(idx_nxt);
                    end
                end
            end
            RREQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    idx_d    = idx_nxt;
                    if (m_axil.RRESP != 2'b00) begin
                        err_d = sat_inc(err_q);
                    end else if (mode_q[1] && (m_axil.RDATA != beat_data(idx_q))) begin
                        mis_d = sat_inc(mis_q);
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = RREQ;
                        arvalid_d = 1'b1;
                        araddr_d  = beat_addr(idx_nxt);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= BASE_ADDR;
            araddr_q  <= BASE_ADDR;
            wdata_q   <= SEED;
            err_q     <= '0;
            mis_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign resp_err_cnt   = err_q;
    assign mismatch_cnt   = mis_q;
    assign m_axil.AWADDR  = awaddr_q;
    assign m_axil.AWPROT  = 3'b010;
    assign m_axil.AWVALID = awvalid_q;
    assign m_axil.WDATA   = wdata_q;
    assign m_axil.WSTRB   = '1;
    assign m_axil.WVALID  = wvalid_q;
    assign m_axil.BREADY  = bready_q;
    assign m_axil.ARADDR  = araddr_q;
    assign m_axil.ARPROT  = 3'b010;
    assign m_axil.ARVALID = arvalid_q;
    assign m_axil.RREADY  = rready_q;
endmodule
